// File: rtl/AlteraAvalon_Pkg.sv
// Avalon-ST beat carried between the stack generators and the MAC: 38 bits per beat.
package AlteraAvalon_Pkg;
  localparam int AVST_DATA_W  = 32;
  localparam int AVST_EMPTY_W = 1;
  localparam int AVST_ERROR_W = 2;

  typedef struct packed {
    logic [AVST_ERROR_W-1:0] Error;
    logic                    Valid;
    logic                    Sop;
    logic                    Eop;
    logic [AVST_EMPTY_W-1:0] Empty;
    logic [AVST_DATA_W-1:0]  Data;
  } From_AvalonST_SourceStruct;
endpackage

// File: rtl/inet_stack_pkg.sv
// Shared types for the inet transmit stack: arbiter states and the abort-beat encoding.
package inet_stack_pkg;
  import AlteraAvalon_Pkg::*;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ABORT
  } arb_state_te;

  localparam logic [1:0] AVST_ERR_ABORT = 2'b11;

  // Errored EOP that closes a frame whose source went silent mid-packet.
  function automatic From_AvalonST_SourceStruct avst_abort_beat();
    From_AvalonST_SourceStruct beat;
    beat       = '0;
    beat.Valid = 1'b1;
    beat.Eop   = 1'b1;
    beat.Error = AVST_ERR_ABORT;
    return beat;
  endfunction
endpackage

// File: rtl/inet_tx_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_oh,
  output logic [W-1:0] grant_idx
);
  int         cand;
  logic [W-1:0] cand_idx;
  logic       found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = W'(cand);
      if (!found && req[cand_idx]) begin
        found              = 1'b1;
        grant_oh[cand_idx] = 1'b1;
        grant_idx          = cand_idx;
      end
    end
  end
endmodule

// File: rtl/inet_tx_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing one Avalon-ST transmit path among NUM_SRC
// framed sources, with a per-grant stall watchdog that closes dead frames with an errored EOP.
module inet_tx_stream_arbiter
  import AlteraAvalon_Pkg::*;
  import inet_stack_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_WIDTH     = 16,
  localparam int GW           = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  From_AvalonST_SourceStruct snk_in [NUM_SRC],
  output logic [NUM_SRC-1:0]        snk_ready,
  input  logic [NUM_SRC-1:0]        src_en,
  output From_AvalonST_SourceStruct src_out,
  input  logic                      src_ready,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      pkt_count,
  output logic [CNT_WIDTH-1:0]      abort_count
);
  localparam logic [GW-1:0]        LAST_SRC = GW'(NUM_SRC - 1);
  localparam logic [15:0]          WD_LAST  = 16'(STALL_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  arb_state_te               state_reg;
  logic [GW-1:0]             grant_reg;
  logic [GW-1:0]             ptr_reg;
  logic [GW-1:0]             ptr_next;
  logic [15:0]               wd_reg;
  logic [CNT_WIDTH-1:0]      pkt_count_reg;
  logic [CNT_WIDTH-1:0]      abort_count_reg;
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC-1:0]        pick_oh;
  logic [GW-1:0]             pick_idx;
  From_AvalonST_SourceStruct granted;

  // Only a valid SOP from an enabled source may open a new packet.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_req
      assign req[gi]       = snk_in[gi].Valid & snk_in[gi].Sop & src_en[gi];
      assign snk_ready[gi] = (state_reg == XFER) && (grant_reg == GW'(gi)) && src_ready;
    end
  endgenerate

  rr_pick #(
    .N (NUM_SRC),
    .W (GW)
  ) u_rr_pick (
    .req       (req),
    .ptr       (ptr_reg),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx)
  );

  assign granted  = snk_in[grant_reg];
  assign ptr_next = (grant_reg == LAST_SRC) ? '0 : grant_reg + GW'(1);

  always_comb begin
    src_out = '0;
    case (state_reg)
      XFER:    src_out = granted;
      ABORT:   src_out = avst_abort_beat();
      default: src_out = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      ptr_reg         <= '0;
      wd_reg          <= '0;
      pkt_count_reg   <= '0;
      abort_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|pick_oh) begin
            grant_reg <= pick_idx;
            wd_reg    <= '0;
            state_reg <= XFER;
          end
        end
        XFER: begin
          // Back-pressure with Valid high is not a stall; only a silent source ages the watchdog.
          if (granted.Valid) begin
            wd_reg <= '0;
            if (src_ready && granted.Eop) begin
              pkt_count_reg <= pkt_count_reg + CNT_ONE;
              ptr_reg       <= ptr_next;
              state_reg     <= IDLE;
            end
          end else if (wd_reg == WD_LAST) begin
            state_reg <= ABORT;
          end else begin
            wd_reg <= wd_reg + 16'd1;
          end
        end
        ABORT: begin
          if (src_ready) begin
            abort_count_reg <= abort_count_reg + CNT_ONE;
            ptr_reg         <= ptr_next;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant_id    = grant_reg;
  assign busy        = (state_reg != IDLE);
  assign pkt_count   = pkt_count_reg;
  assign abort_count = abort_count_reg;
endmodule

// File: tb/tb_inet_tx_stream_arbiter.sv
// Bench for inet_tx_stream_arbiter: queue-driven sources, per-cycle model compare, directed scenarios.
module tb_inet_tx_stream_arbiter;
  import AlteraAvalon_Pkg::*;

  localparam int N  = 4;
  localparam int T  = 4;
  localparam int QD = 32;
  localparam int LD = 256;

  logic clk = 1'b0;
  logic reset;
  From_AvalonST_SourceStruct snk_in [N];
  logic [N-1:0] snk_ready;
  logic [N-1:0] src_en;
  From_AvalonST_SourceStruct src_out;
  logic src_ready;
  logic [1:0] grant_id;
  logic busy;
  logic [15:0] pkt_count;
  logic [15:0] abort_count;

  always #5 clk = ~clk;

  inet_tx_stream_arbiter #(
    .NUM_SRC       (N),
    .STALL_TIMEOUT (T),
    .CNT_WIDTH     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .snk_in      (snk_in),
    .snk_ready   (snk_ready),
    .src_en      (src_en),
    .src_out     (src_out),
    .src_ready   (src_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_count   (pkt_count),
    .abort_count (abort_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source-side packet queues.
  typedef struct packed {
    logic [1:0]  err;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } beat_t;

  beat_t qmem [N][QD];
  int    qhead [N];
  int    qtail [N];
  logic  toggle_ready = 1'b0;

  // Accepted output beats, recorded by the compare process.
  logic [31:0] log_data [LD];
  logic        log_sop  [LD];
  logic        log_eop  [LD];
  logic [1:0]  log_err  [LD];
  int          log_cyc  [LD];
  int          log_n = 0;
  int          cyc   = 0;

  task automatic push_pkt(input int s, input int pk, input int len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.err  = 2'(b & 1);
      x.sop  = (b == 0);
      x.eop  = (b == len - 1);
      x.data = {8'(s), 8'(pk), 16'(b)};
      qmem[s][qtail[s]] = x;
      qtail[s]++;
    end
  endtask

  task automatic clear_queues();
    for (int s = 0; s < N; s++) begin
      qhead[s] = 0;
      qtail[s] = 0;
    end
  endtask

  task automatic apply_inputs();
    for (int s = 0; s < N; s++) begin
      From_AvalonST_SourceStruct v;
      v = '0;
      if (qhead[s] < qtail[s]) begin
        v.Valid = 1'b1;
        v.Sop   = qmem[s][qhead[s]].sop;
        v.Eop   = qmem[s][qhead[s]].eop;
        v.Error = qmem[s][qhead[s]].err;
        v.Empty = qmem[s][qhead[s]].eop;
        v.Data  = qmem[s][qhead[s]].data;
      end
      snk_in[s] = v;
    end
  endtask

  task automatic tick();
    logic [N-1:0] fire;
    @(negedge clk);
    for (int s = 0; s < N; s++) fire[s] = snk_in[s].Valid & snk_ready[s];
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) if (fire[s]) qhead[s]++;
    if (toggle_ready) src_ready = ~src_ready;
    apply_inputs();
  endtask

  task automatic drain(input string name, input logic [N-1:0] m, input int budget);
    int  k;
    bit  empty;
    k = 0;
    empty = 0;
    while (k < budget && !empty) begin
      tick();
      k++;
      empty = !busy;
      for (int s = 0; s < N; s++) if (m[s] && qhead[s] < qtail[s]) empty = 0;
    end
    check({name, "_drain_in_budget"}, 64'(empty), 64'(1));
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_src_out"}, 64'(src_out), 64'(0));
    check({name, "_snk_ready"}, 64'(snk_ready), 64'(0));
    check({name, "_grant_id"}, 64'(grant_id), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_pkt_count"}, 64'(pkt_count), 64'(0));
    check({name, "_abort_count"}, 64'(abort_count), 64'(0));
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_queues();
    apply_inputs();
    #2;
    check_reset_outputs(name);
    @(posedge clk);
    @(posedge clk);
    #1;
    log_n        = 0;
    src_en       = 4'hF;
    src_ready    = 1'b1;
    toggle_ready = 1'b0;
    reset        = 1'b0;
  endtask

  // Behavioural model: who owns the output, rr pointer, silent-cycle count, counters.
  int m_mode;   // 0 = nobody, 1 = source owns path, 2 = abort beat pending
  int m_owner, m_last, m_ptr, m_stall, m_pkts, m_aborts;

  initial begin : compare_proc
    From_AvalonST_SourceStruct e_out;
    logic [N-1:0] e_rdy;
    int s2;
    m_mode = 0; m_owner = 0; m_last = 0; m_ptr = 0; m_stall = 0; m_pkts = 0; m_aborts = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        m_mode = 0; m_owner = 0; m_last = 0; m_ptr = 0; m_stall = 0; m_pkts = 0; m_aborts = 0;
      end else begin
        e_out = '0;
        e_rdy = '0;
        if (m_mode == 1) begin
          e_out = snk_in[m_owner];
          e_rdy[m_owner] = src_ready;
        end else if (m_mode == 2) begin
          e_out.Valid = 1'b1;
          e_out.Eop   = 1'b1;
          e_out.Error = 2'b11;
        end
        if (m_mode == 0) check("src_out_valid", 64'(src_out.Valid), 64'(0));
        else             check("src_out", 64'(src_out), 64'(e_out));
        check("snk_ready", 64'(snk_ready), 64'(e_rdy));
        check("grant_id", 64'(grant_id), 64'(m_last));
        check("busy", 64'(busy), 64'(m_mode != 0));
        check("pkt_count", 64'(pkt_count), 64'(16'(m_pkts)));
        check("abort_count", 64'(abort_count), 64'(16'(m_aborts)));

        if (src_out.Valid && src_ready && log_n < LD) begin
          log_data[log_n] = src_out.Data;
          log_sop[log_n]  = src_out.Sop;
          log_eop[log_n]  = src_out.Eop;
          log_err[log_n]  = src_out.Error;
          log_cyc[log_n]  = cyc;
          log_n++;
        end

        // Advance the model with the inputs the DUT will see at the coming edge.
        case (m_mode)
          0: begin
            for (int k = 0; k < N; k++) begin
              s2 = (m_ptr + k) % N;
              if (m_mode == 0 && snk_in[s2].Valid && snk_in[s2].Sop && src_en[s2]) begin
                m_mode = 1; m_owner = s2; m_last = s2; m_stall = 0;
              end
            end
          end
          1: begin
            if (snk_in[m_owner].Valid) begin
              m_stall = 0;
              if (src_ready && snk_in[m_owner].Eop) begin
                m_pkts++;
                m_ptr  = (m_owner + 1) % N;
                m_mode = 0;
              end
            end else begin
              m_stall++;
              if (m_stall == T) m_mode = 2;
            end
          end
          default: begin
            if (src_ready) begin
              m_aborts++;
              m_ptr  = (m_owner + 1) % N;
              m_mode = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int p_cyc, base, k, pidx, last_eop;
    int exp_order [6];
    reset        = 1'b1;
    src_en       = '0;
    src_ready    = 1'b0;
    clear_queues();
    apply_inputs();

    // Test 1: single 3-beat packet from src1.
    do_reset("t1_reset");
    push_pkt(1, 0, 3);
    apply_inputs();
    p_cyc = cyc + 1;
    drain("t1", 4'hF, 30);
    check("t1_beats", 64'(log_n), 64'(3));
    for (int b = 0; b < 3; b++) begin
      check("t1_data", 64'(log_data[b]), 64'({8'd1, 8'd0, 16'(b)}));
      check("t1_eop", 64'(log_eop[b]), 64'(b == 2));
    end
    check("t1_bubble", 64'(log_cyc[0] - p_cyc), 64'(1));
    check("t1_pkt_count", 64'(pkt_count), 64'(1));
    check("t1_grant_id", 64'(grant_id), 64'(1));

    // Test 2: fairness with all sources streaming 2-beat packets.
    do_reset("t2_reset");
    for (int s = 0; s < N; s++) for (int pk = 0; pk < 3; pk++) push_pkt(s, pk, 2);
    apply_inputs();
    drain("t2", 4'hF, 200);
    exp_order = '{0, 1, 2, 3, 0, 1};
    pidx = 0;
    last_eop = 0;
    for (int i = 0; i < log_n; i++) begin
      if (log_sop[i] && pidx < 6) begin
        check("t2_order", 64'(log_data[i][31:24]), 64'(exp_order[pidx]));
        if (pidx > 0) check("t2_gap", 64'(log_cyc[i] - last_eop), 64'(2));
        pidx++;
      end
      if (log_eop[i]) last_eop = log_cyc[i];
    end
    check("t2_packets_seen", 64'(pidx), 64'(6));
    check("t2_pkt_count", 64'(pkt_count), 64'(12));

    // Test 3: back-pressure toggling every cycle during a 5-beat packet from src2.
    do_reset("t3_reset");
    push_pkt(2, 0, 5);
    toggle_ready = 1'b1;
    apply_inputs();
    drain("t3", 4'hF, 60);
    toggle_ready = 1'b0;
    src_ready    = 1'b1;
    check("t3_beats", 64'(log_n), 64'(5));
    for (int b = 0; b < 5; b++) begin
      check("t3_data", 64'(log_data[b]), 64'({8'd2, 8'd0, 16'(b)}));
      check("t3_eop", 64'(log_eop[b]), 64'(b == 4));
    end

    // Test 4: watchdog on src0 after a lone SOP; src1 waits behind it.
    do_reset("t4_reset");
    push_pkt(0, 0, 4);
    qtail[0] = 1;
    push_pkt(1, 0, 2);
    apply_inputs();
    drain("t4", 4'hF, 100);
    check("t4_beats", 64'(log_n), 64'(4));
    check("t4_first_src", 64'(log_data[0][31:24]), 64'(0));
    check("t4_abort_err", 64'(log_err[1]), 64'(2'b11));
    check("t4_abort_eop", 64'(log_eop[1]), 64'(1));
    check("t4_abort_sop", 64'(log_sop[1]), 64'(0));
    check("t4_abort_data", 64'(log_data[1]), 64'(0));
    check("t4_abort_delay", 64'(log_cyc[1] - log_cyc[0]), 64'(5));
    check("t4_next_src", 64'(log_data[2][31:24]), 64'(1));
    check("t4_abort_count", 64'(abort_count), 64'(1));
    check("t4_pkt_count", 64'(pkt_count), 64'(1));

    // Test 5: src2 masked off; single-beat packet on src3.
    do_reset("t5_reset");
    src_en = 4'b1011;
    push_pkt(0, 0, 2);
    push_pkt(1, 0, 2);
    push_pkt(2, 0, 2);
    push_pkt(3, 0, 1);
    apply_inputs();
    drain("t5", 4'b1011, 100);
    check("t5_beats", 64'(log_n), 64'(5));
    for (int i = 0; i < log_n; i++) check("t5_no_src2", 64'(log_data[i][31:24] == 8'd2), 64'(0));
    check("t5_src3_src", 64'(log_data[4][31:24]), 64'(3));
    check("t5_src3_sop", 64'(log_sop[4]), 64'(1));
    check("t5_src3_eop", 64'(log_eop[4]), 64'(1));
    check("t5_src2_held", 64'(qhead[2]), 64'(0));
    check("t5_pkt_count", 64'(pkt_count), 64'(3));

    // Test 6: reset during beat 2 of src1's 4-beat packet, after src0 moved the pointer.
    qhead[2] = qtail[2];
    src_en   = 4'hF;
    push_pkt(0, 1, 1);
    push_pkt(1, 1, 4);
    apply_inputs();
    base = log_n;
    k = 0;
    while (k < 20 && log_n < base + 2) begin
      tick();
      k++;
    end
    check("t6_reach_beat2", 64'(log_n >= base + 2), 64'(1));
    check("t6_pre_busy", 64'(busy), 64'(1));
    #1;
    reset = 1'b1;
    #2;
    check_reset_outputs("t6_async");
    clear_queues();
    apply_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    log_n = 0;
    reset = 1'b0;
    tick();
    check("t6_idle_busy", 64'(busy), 64'(0));
    check("t6_idle_pkt_count", 64'(pkt_count), 64'(0));
    push_pkt(0, 2, 1);
    push_pkt(1, 2, 1);
    apply_inputs();
    drain("t6", 4'hF, 40);
    check("t6_beats", 64'(log_n), 64'(2));
    check("t6_first_src", 64'(log_data[0][31:24]), 64'(0));
    check("t6_pkt_count", 64'(pkt_count), 64'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inet_tx_stream_arbiter.md
Name: inet_tx_stream_arbiter

Overview:
- Packet-atomic round-robin arbiter. It shares one 32-bit Avalon-ST transmit path among NUM_SRC framed sources (link/IPv4/UDP header generators and payload engines) ahead of the MAC.
- A grant is held from SOP to EOP.
- A per-source watchdog aborts stalled packets and closes them with an errored EOP beat.
- It exposes packet and abort counters for the CSR block.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- STALL_TIMEOUT, 255, idle cycles allowed mid-packet before abort (1..65535).
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- snk_in  in  NUM_SRC x 38  per-source AlteraAvalon_Pkg::From_AvalonST_SourceStruct (Error, Valid, Sop, Eop, Empty, Data).
- snk_ready  out  NUM_SRC  per-source Ready.
- src_en  in  NUM_SRC  per-source arbitration enable mask.
- src_out  out  38  From_AvalonST_SourceStruct toward the MAC.
- src_ready  in  1  downstream Ready.
- grant_id  out  $clog2(NUM_SRC)  currently or last granted source.
- busy  out  1  high in XFER or ABORT.
- pkt_count  out  CNT_WIDTH  completed packets.
- abort_count  out  CNT_WIDTH  watchdog aborts.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; watchdog 0.
- Handshake: ready latency 0. A beat transfers when Valid and Ready are both high in the same cycle.
- States: IDLE, XFER, ABORT.
- IDLE:
  - src_out.Valid = 0; snk_ready = 0.
  - Request vector = snk_in[i].Valid & snk_in[i].Sop & src_en[i].
  - If any request is set, register the first requester found searching from pointer upward (wrapping), set grant_id, and go to XFER next cycle. Arbitration costs exactly 1 bubble cycle.
  - A source whose Valid is high without Sop is not a requester. Its beat is held, not dropped.
- XFER:
  - src_out = snk_in[grant_id], combinational.
  - snk_ready[grant_id] = src_ready; all other snk_ready = 0.
  - src_en deassertion mid-packet has no effect until EOP.
  - When an accepted beat has Eop: pkt_count += 1 (wraps), pointer = grant_id+1 mod NUM_SRC, go to IDLE.
  - A Sop-and-Eop single-beat packet is valid and completes in one XFER cycle.
- Watchdog (XFER only):
  - Counts cycles where the granted source's Valid = 0. It clears on any granted Valid. Cycles with Valid=1 and src_ready=0 are back-pressure and are not counted.
  - When the count reaches STALL_TIMEOUT, go to ABORT.
- ABORT:
  - Drive src_out Valid=1, Sop=0, Eop=1, Error=2'b11, Empty=0, Data=0. All snk_ready = 0.
  - On src_ready: abort_count += 1, pointer = grant_id+1, go to IDLE.
  - The stalled source's late remainder is not purged by this block. Its next non-SOP beats are never granted, and upstream owns recovery.
- Error and Empty pass through unmodified in XFER.
- Back-pressure: src_ready=0 holds all state; no beat is lost or duplicated.
- Reset mid-packet: immediate return to the reset values. A downstream partial frame is allowed; the MAC discards it on its own reset.
- Counters: pkt_count and abort_count roll over at 2^CNT_WIDTH.

Decomposition:
- Shared package: AlteraAvalon_Pkg supplies the stream struct.
- Add to inet_stack_pkg:
  - arb_state_te enum (IDLE, XFER, ABORT).
  - localparam AVST_ERR_ABORT = 2'b11.
- Sub-module rr_pick: combinational round-robin priority picker (request vector, pointer -> one-hot and index). It is reused by later MM arbiters.

Test Plan:
- Single request: src1 sends a 3-beat packet, src_ready=1 -> one bubble cycle, then 3 beats out with grant_id=1, pkt_count=1, snk_ready[0,2,3]=0 throughout.
- Fairness: all 4 sources continuously send 2-beat packets -> output grant order 0,1,2,3,0,1, with one idle cycle between packets.
- Back-pressure: src_ready toggles every cycle during a 5-beat packet from src2 -> exactly 5 beats with Data in order, no duplicates, Eop on the 5th.
- Watchdog: STALL_TIMEOUT=4; src0 sends Sop then drops Valid -> after 4 stalled cycles, one beat with Eop=1 and Error=2'b11; abort_count=1; next grant goes to src1 if it is requesting.
- Mask and single-beat: src_en=4'b1011 with all requesting -> src2 is never granted; a Sop+Eop packet on src3 completes in one XFER cycle.
- Reset mid-packet: assert reset during beat 2 of a 4-beat packet -> all outputs 0 asynchronously; after release, IDLE with pointer 0 and pkt_count=0.
